// File: rtl/trace_capture_controller.sv
// Trace capture session controller: trigger/arm, kept-item buffering, drain and stats.
// Item buffer is a first-word fall-through FIFO; status outputs decode the state register.

// Generic FWFT FIFO with occupancy count.
// Latency: written word visible on rd_dat the cycle after the write.
// Backpressure: wr_rdy drops when full unless a read frees a slot in the same cycle.
module tcc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic [AW:0]      count
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_fire, rd_fire;

  assign rd_vld  = (count_q != '0);
  assign rd_fire = rd_vld && rd_rdy;
  assign wr_rdy  = (count_q != FULL_LVL) || rd_fire;
  assign wr_fire = wr_vld && wr_rdy;
  assign rd_dat  = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_dat;
  end
endmodule

// Trace capture controller: sequences IDLE/ARMED/COLLECTING/DRAINING/DONE around the filter.
// Latency: kept item appears on out_data the cycle after it is presented.
// Backpressure: out_ready stalls the FIFO; halt_cpu raised at threshold, overflow counted as dropped.
module trace_capture_controller #(
  parameter int XLEN           = 64,
  parameter int INSTR_WIDTH    = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int HALT_THRESHOLD = 12,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_start,
  input  logic                        cfg_stop,
  input  logic                        cfg_trigger_en,
  input  logic [XLEN-1:0]             cfg_trigger_pc,
  input  logic [COUNT_WIDTH-1:0]      cfg_item_limit,
  input  logic                        pc_valid,
  input  logic [XLEN-1:0]             pc,
  input  logic [INSTR_WIDTH-1:0]      instr,
  input  logic                        drop_instr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN+INSTR_WIDTH-1:0] out_data,
  output logic                        out_last,
  output logic                        halt_cpu,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [COUNT_WIDTH-1:0]      kept_count,
  output logic [COUNT_WIDTH-1:0]      dropped_count
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] HALT_LVL = (AW+1)'(HALT_THRESHOLD);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [INSTR_WIDTH-1:0] instr;
  } item_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_COLLECTING, S_DRAINING, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] kept_q, kept_d, dropped_q, dropped_d;
  logic [COUNT_WIDTH-1:0] kept_inc, dropped_inc;
  logic                   overflow_q, overflow_d;
  logic                   halt_q, halt_d;

  item_t       wr_item;
  logic        wr_rdy, rd_vld;
  logic [AW:0] fifo_count;
  logic        trig_hit, item_in, keep, push, lost, limit_hit;
  logic        cap_now, cap_next;

  assign wr_item = '{pc: pc, instr: instr};

  tcc_fifo #(
    .WIDTH($bits(item_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (keep),
    .wr_rdy (wr_rdy),
    .wr_dat (wr_item),
    .rd_vld (rd_vld),
    .rd_rdy (out_ready),
    .rd_dat (out_data),
    .count  (fifo_count)
  );

  // The trigger item is captured in the same cycle it moves ARMED to COLLECTING; stop wins over it.
  assign trig_hit  = (state_q == S_ARMED) && !cfg_stop && pc_valid && (pc == cfg_trigger_pc);
  assign item_in   = (pc_valid && (state_q == S_COLLECTING)) || trig_hit;
  assign keep      = item_in && !drop_instr;
  assign push      = keep && wr_rdy;
  assign lost      = keep && !wr_rdy;

  assign kept_inc    = (&kept_q)    ? kept_q    : kept_q + 1'b1;
  assign dropped_inc = (&dropped_q) ? dropped_q : dropped_q + 1'b1;
  assign limit_hit   = push && (cfg_item_limit != '0) && (kept_inc == cfg_item_limit);

  always_comb begin
    state_d    = state_q;
    kept_d     = kept_q;
    dropped_d  = dropped_q;
    overflow_d = overflow_q;
    if (push) kept_d = kept_inc;
    if ((item_in && drop_instr) || lost) dropped_d = dropped_inc;
    if (lost) overflow_d = 1'b1;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_start && !cfg_stop) begin
          state_d    = cfg_trigger_en ? S_ARMED : S_COLLECTING;
          kept_d     = '0;
          dropped_d  = '0;
          overflow_d = 1'b0;
        end
      end
      S_ARMED: begin
        if (cfg_stop)      state_d = S_IDLE;
        else if (trig_hit) state_d = limit_hit ? S_DRAINING : S_COLLECTING;
      end
      S_COLLECTING: begin
        if (cfg_stop || limit_hit) state_d = S_DRAINING;
      end
      S_DRAINING: begin
        if (!rd_vld) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // halt drops in the same cycle the session leaves the capture states.
  assign cap_now  = (state_q == S_ARMED) || (state_q == S_COLLECTING);
  assign cap_next = (state_d == S_ARMED) || (state_d == S_COLLECTING);
  assign halt_d   = cap_now && cap_next && (fifo_count >= HALT_LVL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      kept_q     <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      kept_q     <= kept_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
      halt_q     <= halt_d;
    end
  end

  assign out_valid     = rd_vld;
  assign out_last      = rd_vld && (state_q == S_DRAINING) && (fifo_count == ONE_LVL);
  assign halt_cpu      = halt_q;
  assign busy          = (state_q == S_ARMED) || (state_q == S_COLLECTING) || (state_q == S_DRAINING);
  assign done          = (state_q == S_DONE);
  assign overflow      = overflow_q;
  assign kept_count    = kept_q;
  assign dropped_count = dropped_q;
endmodule
